// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC acquisition write path.
package adc_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FIFO_W   = 64;

  typedef enum logic {IDLE, FILL} pack_state_t;

  typedef logic [FIFO_W-1:0] fifo_word_t;

endpackage

// File: rtl/adc_sample_packer_if.sv
// Write port of the 64-bit dual-clock FIFO as seen from the packer.
interface adc_sample_packer_if;
  import adc_pkg::*;

  logic       wrreq;
  fifo_word_t wr_data;
  logic       wrfull;

  modport master (output wrreq, output wr_data, input wrfull);
  modport slave  (input wrreq, input wr_data, output wrfull);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; a same-cycle clear and increment yields a count of one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear first, then apply the increment, stopping at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs four ADC samples into one FIFO word, aligned to the channel-0 marker,
// with a single pending word to ride out short FIFO-full periods.
//
//   state | meaning
//   IDLE  | waiting for an enabled channel-0 sample
//   FILL  | collecting lanes; index selects the next lane
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int SAMPLE_W         = 16,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int DROP_CNT_W       = 16
) (
  input  logic                  wrclk,
  input  logic                  clear_n,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample_data,
  input  logic                  sample_first,
  input  logic                  clr_stat,
  adc_sample_packer_if.master   fifo,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  overflow,
  output logic                  align_err
);

  localparam int IDX_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

  pack_state_t      state;
  logic [IDX_W-1:0] idx;
  fifo_word_t       acc;
  logic             pend_valid;
  fifo_word_t       pend_word;

  logic             accept;
  logic             realign;
  logic [IDX_W-1:0] lane_idx;
  logic             word_done;
  logic             wrreq_i;
  logic             drop;
  fifo_word_t       next_word;

  // Decode the incoming sample: which lane it lands in and whether it closes a word.
  always_comb begin
    accept    = sample_valid & enable & ((state == FILL) | sample_first);
    realign   = (state == FILL) & enable & sample_valid & sample_first & (idx != '0);
    lane_idx  = sample_first ? '0 : idx;
    word_done = accept & (lane_idx == LAST_IDX);
    wrreq_i   = pend_valid & ~fifo.wrfull;
    drop      = word_done & pend_valid & ~wrreq_i;
    next_word = acc;
    for (int l = 0; l < SAMPLES_PER_WORD; l++) begin
      if (lane_idx == IDX_W'(l)) begin
        next_word[l*SAMPLE_W +: SAMPLE_W] = sample_data;
      end
    end
  end

  assign fifo.wrreq   = wrreq_i;
  assign fifo.wr_data = pend_word;

  // Framing FSM, pending word and sticky flags.
  always_ff @(posedge wrclk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
      overflow   <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      if (!enable) begin
        state <= IDLE;
        idx   <= '0;
      end else if (accept) begin
        state <= FILL;
        acc   <= next_word;
        idx   <= word_done ? '0 : lane_idx + IDX_W'(1);
      end

      // Oldest word wins: a completion only loads when the slot is free or draining.
      if (word_done && (!pend_valid || wrreq_i)) begin
        pend_valid <= 1'b1;
        pend_word  <= next_word;
      end else if (wrreq_i) begin
        pend_valid <= 1'b0;
      end

      overflow  <= (overflow  & ~clr_stat) | drop;
      align_err <= (align_err & ~clr_stat) | realign;
    end
  end

  sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
    .clk   (wrclk),
    .rst_n (clear_n),
    .inc   (drop),
    .clr   (clr_stat),
    .count (drop_count)
  );

endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

- Write-side front end of the ADC acquisition path, directly upstream of the 64-bit dual-clock FIFO.
- Takes a stream of 16-bit ADC samples and packs four consecutive samples into one 64-bit word, aligned to the channel-0 frame marker.
- Writes each packed word into the FIFO write port, honouring `wrfull`.
- Buffers one word while the FIFO is full and counts words it has to discard.

## Interface
Parameters:
- `SAMPLE_W`, 16: ADC sample width.
- `SAMPLES_PER_WORD`, 4: samples per FIFO word. `SAMPLE_W*SAMPLES_PER_WORD` must equal 64.
- `DROP_CNT_W`, 16: drop counter width.

Ports:
- `wrclk`  in  1  single clock, the FIFO write-domain clock.
- `clear_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  acquisition enable, level.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  `SAMPLE_W`  ADC sample.
- `sample_first`  in  1  qualified by `sample_valid`; marks the channel-0 sample, i.e. the start of a word.
- `clr_stat`  in  1  single-cycle pulse; clears `drop_count` and `overflow`.
- `wrfull`  in  1  FIFO write-side full flag.
- `wrreq`  out  1  FIFO write request.
- `wr_data`  out  64  FIFO write data.
- `drop_count`  out  `DROP_CNT_W`  completed words discarded; saturating.
- `overflow`  out  1  sticky; set on any drop.
- `align_err`  out  1  sticky; set when a partial word is discarded by realignment. Cleared by `clr_stat`.

## Operation
- FSM states: `IDLE`, `FILL`.
- `IDLE`:
  - Samples are ignored until `enable & sample_valid & sample_first`.
  - On that sample: store it in lane 0, set index=1, go to `FILL`.
- `FILL`:
  - Each `sample_valid` stores `sample_data` into lane `index`, bits `[16*index+15 : 16*index]`, so sample 0 sits in the LSBs. Index then increments.
  - On the 4th sample the word is complete and index returns to 0. The FSM stays in `FILL`.
  - `sample_first` with index≠0: the partial word is discarded, `align_err` is set, and the sample is stored as lane 0 with index=1.
  - `sample_first` with index=0 is normal.
  - `sample_valid` with `sample_first` low and index=0 starts a new word without error. Alignment is checked only by marker.
  - `enable` low: go to `IDLE`, index=0, partial word discarded without error. A pending word still drains.
- Pending register (one word):
  - A completed word loads into pending and sets `pend_valid`.
  - `wrreq = pend_valid & ~wrfull`, combinational from the registered `pend_valid`. `wr_data` is the pending register.
  - `pend_valid` clears on a cycle where `wrreq`=1.
- Completion while `pend_valid` is set and not draining that cycle:
  - The new word is dropped; the pending word is kept (oldest wins).
  - `drop_count` increments, saturating at all-ones; `overflow` is set.
- Completion in the same cycle the pending word drains (`wrreq`=1): the new word loads with no drop.
- `clr_stat` coinciding with a drop: clear is applied first, then the increment, giving `drop_count`=1 and `overflow`=1.
- Reset values:
  - State `IDLE`, index 0, `pend_valid` 0.
  - `wrreq` 0, `wr_data` 0, `drop_count` 0, `overflow` 0, `align_err` 0.
- Reset mid-word or with a word pending: everything is discarded and no write is issued.

## Timing
- Completing sample accepted in cycle n: `pend_valid` high in n+1. If `wrfull`=0, `wrreq` is high in n+1, held for exactly one cycle.
- Sustained rate: one sample per cycle, one word every 4 cycles. Throughput is lossless while `wrfull` is never high for 4 or more consecutive cycles around a completion.
- `wrfull` rising while `pend_valid`=1: `wrreq` drops in the same cycle. The word is held until the first cycle with `wrfull`=0.
- `align_err`, `overflow` and `drop_count` update on the cycle after the causing event.

## Structure
- Package `adc_pkg` holds:
  - `SAMPLE_W` and `FIFO_W`=64.
  - `typedef enum logic {IDLE, FILL} pack_state_t`.
  - `typedef logic [FIFO_W-1:0] fifo_word_t`.
- One natural sub-module, `sat_counter`: parameterised width, `inc`/`clr` inputs with clear-then-increment semantics. Used for `drop_count`.
- Everything else lives in `adc_sample_packer`.

## Test plan
- **Basic pack:** `enable`=1, `wrfull`=0; samples 0x1111 (first), 0x2222, 0x3333, 0x4444 on back-to-back cycles. Expect one `wrreq` pulse with `wr_data`=0x4444_3333_2222_1111, one cycle after the 4th sample.
- **Realignment:** first, 0xAAAA, 0xBBBB, then first 0x0001, 0x0002, 0x0003, 0x0004. Expect `align_err`=1 and a single write of 0x0004_0003_0002_0001.
- **Backpressure hold:** `wrfull`=1 from before completion for 3 cycles. Expect `wrreq`=0 while full, then exactly one write of the held word when `wrfull` falls. `drop_count`=0.
- **Overflow:** `wrfull` held 1 across two completions, words W1 then W2. Expect W2 dropped, `drop_count`=1, `overflow`=1, and W1 written after `wrfull` falls. Then `clr_stat` gives 0/0.
- **Saturation and collision:** with `DROP_CNT_W`=2, force 5 drops → `drop_count`=3. Then `clr_stat` in the same cycle as a drop → `drop_count`=1.
- **Reset mid-operation:** pulse `clear_n` low after 2 samples and with a word pending. Expect all outputs 0 and no `wrreq`. The next word packs from a fresh `sample_first`.
